// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding, the out-of-range NOP word and default sizing.
package imem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_READ = 2'd2;
    localparam state_t ST_ACK  = 2'd3;

    localparam logic [31:0] NOP_WORD = 32'hE1A00000;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/imem_responder_toggle_sync.sv
// Two-flop synchronizer for a two-phase toggle input plus compare against the local phase.
// Latency 2 cycles to diff_out; no backpressure, the owner decides when to consume a request.
module toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic tgl_in,
    input  logic phase_in,
    output logic chg_out,
    output logic diff_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = tgl_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // chg_out flags that the synchronized level will change on the next edge
    assign chg_out  = sync1_q ^ sync2_q;
    assign diff_out = sync2_q ^ phase_in;

endmodule

// File: rtl/imem_responder.sv
// Two-phase handshake instruction memory: one word per trigger toggle, errOut on bad address.
// readyOut toggles LATENCY+4 edges after the trigger; a toggle while busy is flagged, not queued.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     triggerIn,
    input  logic [31:0]              addrIn,
    output logic                     readyOut,
    output logic [31:0]              dataOut,
    output logic                     errOut,
    output logic                     busyOut,
    output logic                     protoErr,
    input  logic                     loadEn,
    input  logic [$clog2(DEPTH)-1:0] loadAddr,
    input  logic [31:0]              loadData
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        perr_q, perr_d;

    logic [31:0] mem_q [DEPTH];

    logic          trig_chg;
    logic          req_pend;
    logic          busy;
    logic [AW-1:0] word_idx;
    logic          misalign;
    logic          out_of_range;

    // readyOut doubles as the phase register the synchronized trigger is compared with
    toggle_sync u_toggle_sync (
        .clk      (clk),
        .rst      (rst),
        .tgl_in   (triggerIn),
        .phase_in (ready_q),
        .chg_out  (trig_chg),
        .diff_out (req_pend)
    );

    assign busy         = (state_q != ST_IDLE);
    assign word_idx     = addr_q[AW+1:2];
    assign misalign     = |addr_q[1:0];
    assign out_of_range = |addr_q[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        ready_d = ready_q;
        perr_d  = perr_q | (busy & trig_chg);
        case (state_q)
            ST_IDLE: begin
                if (req_pend) begin
                    state_d = ST_WAIT;
                    addr_d  = addrIn;
                    cnt_d   = LAT_INIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd2) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_ACK;
                data_d  = out_of_range ? NOP_WORD : mem_q[word_idx];
                err_d   = misalign | out_of_range;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = ~ready_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            perr_q  <= perr_d;
        end
    end

    // Contents survive reset so a boot image loaded once stays valid
    always_ff @(posedge clk) begin
        if (loadEn) begin
            mem_q[loadAddr] <= loadData;
        end
    end

    assign readyOut = ready_q;
    assign dataOut  = data_q;
    assign errOut   = err_q;
    assign busyOut  = busy;
    assign protoErr = perr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder with a word-array reference model.
module tb_imem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        triggerIn = 1'b0;
    logic [31:0] addrIn = 32'd0;
    logic        readyOut;
    logic [31:0] dataOut;
    logic        errOut;
    logic        busyOut;
    logic        protoErr;
    logic        loadEn = 1'b0;
    logic [7:0]  loadAddr = 8'd0;
    logic [31:0] loadData = 32'd0;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .triggerIn (triggerIn),
        .addrIn    (addrIn),
        .readyOut  (readyOut),
        .dataOut   (dataOut),
        .errOut    (errOut),
        .busyOut   (busyOut),
        .protoErr  (protoErr),
        .loadEn    (loadEn),
        .loadAddr  (loadAddr),
        .loadData  (loadData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ref_mem [DEPTH];
    logic [32:0] exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          tgl_cyc = 0;
    int          resp_cyc = 0;
    logic        last_ready = 1'b0;
    logic [32:0] mon_exp;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected {err, data} straight from the address rules
    function automatic logic [32:0] model(input logic [31:0] a);
        logic [31:0] nop;
        nop = 32'hE1A00000;
        if (a >= 32'(4 * DEPTH)) return {1'b1, nop};
        return {(a % 4) != 0, ref_mem[a / 4]};
    endfunction

    always @(posedge clk) begin
        #1;
        if (readyOut !== last_ready) begin
            last_ready = readyOut;
            resp_cyc   = cyc;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got %h with no request pending", {errOut, dataOut});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp", {errOut, dataOut}, mon_exp);
            end
        end
    end

    task automatic load(input int w, input logic [31:0] d);
        @(negedge clk);
        loadEn   = 1'b1;
        loadAddr = 8'(w);
        loadData = d;
        @(negedge clk);
        loadEn = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic issue(input logic [31:0] a);
        @(negedge clk);
        addrIn    = a;
        triggerIn = ~triggerIn;
        tgl_cyc   = cyc;
        exp_q.push_back(model(a));
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (readyOut == triggerIn && !busyOut) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s_timeout: readyOut %b never matched triggerIn %b", name, readyOut, triggerIn);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          c;

        repeat (2) @(negedge clk);
        chk("rst_ready", {32'd0, readyOut}, 33'd0);
        chk("rst_data",  {1'b0, dataOut},   33'd0);
        chk("rst_err",   {32'd0, errOut},   33'd0);
        chk("rst_busy",  {32'd0, busyOut},  33'd0);
        chk("rst_perr",  {32'd0, protoErr}, 33'd0);
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++) load(w, $urandom);
        load(3, 32'hE3A01005);

        // Basic fetch: latency, and data valid one cycle before readyOut
        issue(32'h0C);
        c = tgl_cyc;
        repeat (5) @(negedge clk);
        chk("data_leads_ready", {1'b0, dataOut}, {1'b0, 32'hE3A01005});
        chk("ready_not_yet",    {32'd0, readyOut}, 33'd0);
        wait_done("basic");
        chk("latency", 33'(resp_cyc - c), 33'd6);

        foreach (ref_mem[i]) if (i < 0) $display("unused");
        for (int k = 0; k < 4; k++) begin
            issue(32'(4 * k));
            wait_done("b2b");
        end
        chk("perr_b2b", {32'd0, protoErr}, 33'd0);

        issue(32'h402);  wait_done("oor");
        issue(32'h0E);   wait_done("misalign");
        issue(32'h3FC);  wait_done("last_word");
        issue(32'h400);  wait_done("first_oor");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1) load($urandom_range(0, DEPTH - 1), $urandom);
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r < 8) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else            a = $urandom | 32'h0000_0400;
            issue(a);
            wait_done("rand");
        end
        chk("perr_rand", {32'd0, protoErr}, 33'd0);

        // Write landing on the read edge must not leak into this response
        issue(32'h0C);
        repeat (4) @(posedge clk);
        @(negedge clk);
        loadEn   = 1'b1;
        loadAddr = 8'd3;
        loadData = 32'hCAFE_0003;
        @(negedge clk);
        loadEn = 1'b0;
        ref_mem[3] = 32'hCAFE_0003;
        wait_done("rd_wr_old");
        issue(32'h0C);
        wait_done("rd_wr_new");

        // Second toggle while the first request is still in WAIT
        issue(32'h10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_in_wait", {32'd0, busyOut}, 33'd1);
        triggerIn = ~triggerIn;
        exp_q.push_back(model(32'h10));
        wait_done("proto");
        chk("perr_set", {32'd0, protoErr}, 33'd1);

        // Reset mid-request, trigger held high through release
        if (triggerIn) begin
            issue(32'h20);
            wait_done("realign");
        end
        @(negedge clk);
        addrIn    = 32'h24;
        triggerIn = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ready", {32'd0, readyOut}, 33'd0);
        chk("rst_mid_busy",  {32'd0, busyOut},  33'd0);
        chk("rst_mid_perr",  {32'd0, protoErr}, 33'd0);
        repeat (2) @(negedge clk);
        exp_q.push_back(model(32'h24));
        rst = 1'b0;
        wait_done("post_rst");
        chk("post_rst_ready", {32'd0, readyOut}, 33'd1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 33'(exp_q.size()), 33'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
